fuec_stream_decoder: RTL and testbench



---
 rtl/fuec_pkg.sv | 39 +++
 rtl/fuec_stream_decoder_if.sv | 31 +++
 rtl/fuec_syndrome_match.sv | 49 ++++
 rtl/fuec_stream_decoder.sv | 169 ++++++++++++++++
 tb/tb_fuec_stream_decoder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fuec_pkg.sv
// Shared constants, status encoding and syndrome helper for the FUEC stream decoder.
// The optional statistics counters in the top are built only when FUEC_STATS_EN is defined.
package fuec_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_RED_W  = 4;
    localparam logic [47:0] DEFAULT_H = 48'h8421_3AE5_CDF7;

    localparam int MAX_CW_W  = 32;
    localparam int MAX_RED_W = 8;
    localparam int MAX_H_W   = MAX_CW_W * MAX_RED_W;
    localparam int CW_IDX_W  = $clog2(MAX_CW_W);
    localparam int H_IDX_W   = $clog2(MAX_H_W);

    typedef enum logic [1:0] {
        NO_ERR = 2'd0,
        CORR   = 2'd1,
        UNCORR = 2'd2
    } fuec_status_e;

    // Syndrome bit r: XOR of row r of every H column whose codeword bit is set.
    function automatic logic fuec_syndrome_bit(
        input logic [MAX_CW_W-1:0] cw,
        input logic [MAX_H_W-1:0]  h,
        input int                  cw_w,
        input int                  red_w,
        input int                  r
    );
        logic acc;
        acc = 1'b0;
        for (int j = 0; j < MAX_CW_W; j++) begin
            if (j < cw_w && cw[CW_IDX_W'(j)]) begin
                acc = acc ^ h[H_IDX_W'(j * red_w + r)];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/fuec_stream_decoder_if.sv
// Valid/ready stream bundle between a codeword producer/result consumer and the FUEC decoder.
// The master modport is the environment side, the slave modport is the decoder side.
interface fuec_stream_decoder_if #(
    parameter int DATA_W = 8,
    parameter int RED_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [RED_W-1:0]  in_red;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] out_pos_error;
    logic [RED_W-1:0]  out_syndrome;
    logic              out_no_error;
    logic              out_corrected;
    logic              out_uncorrectable;

    modport master (
        output in_valid, in_data, in_red, out_ready,
        input  in_ready, out_valid, out_data, out_pos_error, out_syndrome,
               out_no_error, out_corrected, out_uncorrectable
    );

    modport slave (
        input  in_valid, in_data, in_red, out_ready,
        output in_ready, out_valid, out_data, out_pos_error, out_syndrome,
               out_no_error, out_corrected, out_uncorrectable
    );
endinterface

// File: rtl/fuec_syndrome_match.sv
// Combinational syndrome classifier: compares a syndrome against every H column and
// returns the one-hot data error position plus the decode status (lowest column wins).
module fuec_syndrome_match
    import fuec_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int RED_W  = DEFAULT_RED_W,
    parameter logic [RED_W*(DATA_W+RED_W)-1:0] H_MATRIX = DEFAULT_H
) (
    input  logic [RED_W-1:0]  syndrome,
    output logic [DATA_W-1:0] pos_error,
    output fuec_status_e      status
);

    localparam int CW_W = DATA_W + RED_W;

    logic [CW_W-1:0] col_match;
    logic [CW_W-1:0] first_hit;
    logic            seen;

    always_comb begin
        col_match = '0;
        for (int j = 0; j < CW_W; j++) begin
            col_match[j] = (syndrome == H_MATRIX[j*RED_W +: RED_W]);
        end
    end

    // Keep only the lowest matching column so a duplicated column cannot flip two bits.
    always_comb begin
        first_hit = '0;
        seen      = 1'b0;
        for (int j = 0; j < CW_W; j++) begin
            first_hit[j] = col_match[j] && !seen;
            seen         = seen || col_match[j];
        end
    end

    always_comb begin
        pos_error = '0;
        status    = UNCORR;
        if (syndrome == '0) begin
            status = NO_ERR;
        end else if (|first_hit) begin
            status    = CORR;
            pos_error = first_hit[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/fuec_stream_decoder.sv
// Two-stage pipelined FUEC decoder on a valid/ready stream: S1 registers the syndrome,
// S2 registers corrected data and flags. Optional counters are enabled by FUEC_STATS_EN.
module fuec_stream_decoder
    import fuec_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int RED_W  = DEFAULT_RED_W,
    parameter logic [RED_W*(DATA_W+RED_W)-1:0] H_MATRIX = DEFAULT_H,
    parameter int SAT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fuec_stream_decoder_if.slave bus,
    input  logic                 stat_clr,
    output logic [SAT_W-1:0]     stat_corr_cnt,
    output logic [SAT_W-1:0]     stat_unc_cnt
);

    localparam int CW_W = DATA_W + RED_W;
    localparam logic [MAX_H_W-1:0] H_EXT = MAX_H_W'(H_MATRIX);

    logic                s2_load;
    logic                s1_load;
    logic                accept;
    logic [MAX_CW_W-1:0] cw_ext;

    logic                s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]   s1_data_q, s1_data_d;
    logic [RED_W-1:0]    s1_syn_q, s1_syn_d;

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [DATA_W-1:0]   out_pos_q, out_pos_d;
    logic [RED_W-1:0]    out_syn_q, out_syn_d;
    logic                out_no_err_q, out_no_err_d;
    logic                out_corr_q, out_corr_d;
    logic                out_unc_q, out_unc_d;

    logic [DATA_W-1:0]   m_pos;
    fuec_status_e        m_status;

    // in_ready looks through to out_ready so a full pipeline still streams 1 word/cycle.
    always_comb begin
        s2_load = !out_valid_q || bus.out_ready;
        s1_load = !s1_valid_q || s2_load;
        accept  = bus.in_valid && s1_load;
    end

    assign bus.in_ready = s1_load;

    always_comb begin
        cw_ext           = '0;
        cw_ext[CW_W-1:0] = {bus.in_red, bus.in_data};
        s1_valid_d       = s1_load ? accept : s1_valid_q;
        s1_data_d        = s1_data_q;
        s1_syn_d         = s1_syn_q;
        if (accept) begin
            s1_data_d = bus.in_data;
            for (int r = 0; r < RED_W; r++) begin
                s1_syn_d[r] = fuec_syndrome_bit(cw_ext, H_EXT, CW_W, RED_W, r);
            end
        end
    end

    fuec_syndrome_match #(
        .DATA_W   (DATA_W),
        .RED_W    (RED_W),
        .H_MATRIX (H_MATRIX)
    ) u_match (
        .syndrome  (s1_syn_q),
        .pos_error (m_pos),
        .status    (m_status)
    );

    always_comb begin
        out_valid_d  = s2_load ? s1_valid_q : out_valid_q;
        out_data_d   = out_data_q;
        out_pos_d    = out_pos_q;
        out_syn_d    = out_syn_q;
        out_no_err_d = out_no_err_q;
        out_corr_d   = out_corr_q;
        out_unc_d    = out_unc_q;
        if (s2_load && s1_valid_q) begin
            out_data_d   = s1_data_q ^ m_pos;
            out_pos_d    = m_pos;
            out_syn_d    = s1_syn_q;
            out_no_err_d = (m_status == NO_ERR);
            out_corr_d   = (m_status == CORR);
            out_unc_d    = (m_status == UNCORR);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_syn_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_pos_q    <= '0;
            out_syn_q    <= '0;
            out_no_err_q <= 1'b0;
            out_corr_q   <= 1'b0;
            out_unc_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_syn_q     <= s1_syn_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_pos_q    <= out_pos_d;
            out_syn_q    <= out_syn_d;
            out_no_err_q <= out_no_err_d;
            out_corr_q   <= out_corr_d;
            out_unc_q    <= out_unc_d;
        end
    end

    assign bus.out_valid         = out_valid_q;
    assign bus.out_data          = out_data_q;
    assign bus.out_pos_error     = out_pos_q;
    assign bus.out_syndrome      = out_syn_q;
    assign bus.out_no_error      = out_no_err_q;
    assign bus.out_corrected     = out_corr_q;
    assign bus.out_uncorrectable = out_unc_q;

`ifdef FUEC_STATS_EN
    logic             out_fire;
    logic [SAT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [SAT_W-1:0] unc_cnt_q, unc_cnt_d;

    // Saturating counters; a clear wins over a same-cycle increment.
    always_comb begin
        out_fire   = out_valid_q && bus.out_ready;
        corr_cnt_d = corr_cnt_q;
        unc_cnt_d  = unc_cnt_q;
        if (stat_clr) begin
            corr_cnt_d = '0;
            unc_cnt_d  = '0;
        end else if (out_fire) begin
            if (out_corr_q && corr_cnt_q != '1) begin
                corr_cnt_d = corr_cnt_q + SAT_W'(1);
            end
            if (out_unc_q && unc_cnt_q != '1) begin
                unc_cnt_d = unc_cnt_q + SAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            corr_cnt_q <= '0;
            unc_cnt_q  <= '0;
        end else begin
            corr_cnt_q <= corr_cnt_d;
            unc_cnt_q  <= unc_cnt_d;
        end
    end

    assign stat_corr_cnt = corr_cnt_q;
    assign stat_unc_cnt  = unc_cnt_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_corr_cnt   = '0;
    assign stat_unc_cnt    = '0;
`endif

endmodule

// File: tb/tb_fuec_stream_decoder.sv
// Directed self-checking bench for fuec_stream_decoder with hand-computed expectations
// for the default H (columns 7,F,D,C,5,E,A,3 | 1,2,4,8); stats checks use FUEC_STATS_EN.
module tb_fuec_stream_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stat_clr;
    logic [15:0] stat_corr_cnt;
    logic [15:0] stat_unc_cnt;

    int check_count = 0;
    int error_count = 0;

    fuec_stream_decoder_if #(.DATA_W(8), .RED_W(4)) bus ();

    fuec_stream_decoder #(
        .DATA_W   (8),
        .RED_W    (4),
        .H_MATRIX (48'h8421_3AE5_CDF7),
        .SAT_W    (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .stat_clr      (stat_clr),
        .stat_corr_cnt (stat_corr_cnt),
        .stat_unc_cnt  (stat_unc_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkResult(input string prefix, input logic [7:0] ed, input logic [7:0] ep,
                               input logic [3:0] es, input logic [2:0] flags);
        checkOutput({prefix, "_valid"}, 32'(bus.out_valid), 32'(1));
        checkOutput({prefix, "_data"}, 32'(bus.out_data), 32'(ed));
        checkOutput({prefix, "_pos"}, 32'(bus.out_pos_error), 32'(ep));
        checkOutput({prefix, "_syn"}, 32'(bus.out_syndrome), 32'(es));
        checkOutput({prefix, "_flags"},
                    32'({bus.out_no_error, bus.out_corrected, bus.out_uncorrectable}), 32'(flags));
    endtask

    // Presents one word at posedge+1 and returns once it has been accepted.
    task automatic applyStimulus(input logic [7:0] d, input logic [3:0] r);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_red   = r;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic runSingle(input string prefix, input logic [7:0] d, input logic [3:0] r,
                             input logic [7:0] ed, input logic [7:0] ep,
                             input logic [3:0] es, input logic [2:0] flags);
        applyStimulus(d, r);
        @(negedge clk);
        checkOutput({prefix, "_early"}, 32'(bus.out_valid), 32'(0));
        @(posedge clk);
        @(negedge clk);
        checkResult(prefix, ed, ep, es, flags);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bp_d  [4] = '{8'hA5, 8'h00, 8'hFF, 8'h25};
    logic [3:0] bp_r  [4] = '{4'h7, 4'h0, 4'hB, 4'h7};
    logic [7:0] bp_ed [4] = '{8'hA5, 8'h00, 8'hFF, 8'hA5};
    logic [7:0] bp_ep [4] = '{8'h00, 8'h00, 8'h00, 8'h80};

    initial begin
        int  idx_in;
        int  idx_out;
        logic acc;

        rst_n        = 1'b0;
        stat_clr     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_red   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'(0));
        checkOutput("rst_out_data", 32'(bus.out_data), 32'(0));
        checkOutput("rst_pos", 32'(bus.out_pos_error), 32'(0));
        checkOutput("rst_syn", 32'(bus.out_syndrome), 32'(0));
        checkOutput("rst_flags",
                    32'({bus.out_no_error, bus.out_corrected, bus.out_uncorrectable}), 32'(0));
        checkOutput("rst_stats", 32'({stat_corr_cnt, stat_unc_cnt}), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single-word decode vectors");
        runSingle("clean",   8'hA5, 4'h7, 8'hA5, 8'h00, 4'h0, 3'b100);
        runSingle("data_b3", 8'hAD, 4'h7, 8'hA5, 8'h08, 4'hC, 3'b010);
        runSingle("red_b0",  8'hA5, 4'h6, 8'hA5, 8'h00, 4'h1, 3'b010);
        runSingle("double",  8'hAC, 4'h7, 8'hAC, 8'h00, 4'hB, 3'b001);
        runSingle("data_b7", 8'h25, 4'h7, 8'hA5, 8'h80, 4'h3, 3'b010);
        runSingle("data_b0", 8'hA4, 4'h7, 8'hA5, 8'h01, 4'h7, 3'b010);
        runSingle("red_b3",  8'hA5, 4'hF, 8'hA5, 8'h00, 4'h8, 3'b010);
        runSingle("all_one", 8'hFF, 4'hB, 8'hFF, 8'h00, 4'h0, 3'b100);

`ifdef FUEC_STATS_EN
        checkOutput("stat_corr_pre", 32'(stat_corr_cnt), 32'(5));
        checkOutput("stat_unc_pre", 32'(stat_unc_cnt), 32'(1));
`else
        checkOutput("stat_off_corr", 32'(stat_corr_cnt), 32'(0));
        checkOutput("stat_off_unc", 32'(stat_unc_cnt), 32'(0));
`endif

        $display("[TB] reset while a word is in flight");
        applyStimulus(8'hAD, 4'h7);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_valid0", 32'(bus.out_valid), 32'(0));
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_valid1", 32'(bus.out_valid), 32'(0));
        checkOutput("midrst_stats", 32'({stat_corr_cnt, stat_unc_cnt}), 32'(0));
        @(posedge clk);
        #1;

        $display("[TB] backpressure with 4 words");
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = bp_d[0];
        bus.in_red    = bp_r[0];
        @(negedge clk);
        checkOutput("bp_ready0", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #1;
        bus.in_data = bp_d[1];
        bus.in_red  = bp_r[1];
        @(negedge clk);
        checkOutput("bp_ready1", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #1;
        bus.in_data = bp_d[2];
        bus.in_red  = bp_r[2];
        @(negedge clk);
        checkOutput("bp_ready_low", 32'(bus.in_ready), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("bp_hold%0d_ready", i), 32'(bus.in_ready), 32'(0));
            checkOutput($sformatf("bp_hold%0d_valid", i), 32'(bus.out_valid), 32'(1));
            checkOutput($sformatf("bp_hold%0d_data", i), 32'(bus.out_data), 32'(8'hA5));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        idx_in  = 2;
        idx_out = 0;
        for (int cyc = 0; cyc < 20 && idx_out < 4; cyc++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                checkOutput($sformatf("bp_out%0d_data", idx_out), 32'(bus.out_data),
                            32'(bp_ed[idx_out]));
                checkOutput($sformatf("bp_out%0d_pos", idx_out), 32'(bus.out_pos_error),
                            32'(bp_ep[idx_out]));
                idx_out++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                idx_in++;
                if (idx_in < 4) begin
                    bus.in_data = bp_d[idx_in];
                    bus.in_red  = bp_r[idx_in];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        checkOutput("bp_count", 32'(idx_out), 32'(4));
        @(negedge clk);
        checkOutput("bp_drained", 32'(bus.out_valid), 32'(0));
        @(posedge clk);
        #1;

`ifdef FUEC_STATS_EN
        $display("[TB] statistics counters");
        checkOutput("stat_bp_corr", 32'(stat_corr_cnt), 32'(1));
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        @(negedge clk);
        checkOutput("stat_clr_idle", 32'({stat_corr_cnt, stat_unc_cnt}), 32'(0));
        @(posedge clk);
        #1;
        applyStimulus(8'hAD, 4'h7);
        applyStimulus(8'hA5, 4'h6);
        applyStimulus(8'h25, 4'h7);
        applyStimulus(8'hAC, 4'h7);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("stat_corr3", 32'(stat_corr_cnt), 32'(3));
        checkOutput("stat_unc1", 32'(stat_unc_cnt), 32'(1));
        @(posedge clk);
        #1;
        applyStimulus(8'hAD, 4'h7);
        @(posedge clk);
        #1;
        stat_clr = 1'b1;
        @(negedge clk);
        checkOutput("stat_hs_corr", 32'({bus.out_valid, bus.out_corrected}), 32'(2'b11));
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        @(negedge clk);
        checkOutput("stat_clr_corr", 32'(stat_corr_cnt), 32'(0));
        checkOutput("stat_clr_unc", 32'(stat_unc_cnt), 32'(0));
`else
        stat_clr = 1'b1;
        runSingle("clr_ignored", 8'hAD, 4'h7, 8'hA5, 8'h08, 4'hC, 3'b010);
        stat_clr = 1'b0;
        checkOutput("stat_off_final", 32'({stat_corr_cnt, stat_unc_cnt}), 32'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
